// File: rtl/sram_arbiter.sv
`default_nettype none
// sram_arbiter: shares four byte-addressed 16-bit async SRAM chips between a video and a CPU port.
// Round-robin on ties; each access runs SETUP, ACCESS_CYCLES strobe cycles, then HOLD with the ack.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk_100,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [18:0] sram_a,
    output logic [15:0] sram_d_o,
    output logic        sram_d_oe_hi,
    output logic        sram_d_oe_lo,
    input  logic [15:0] sram_d_i,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic [3:0]  sram_ce_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // Owner of the current access; in IDLE it is the last grant, reset to CPU.
    logic        gnt_cpu_q, gnt_cpu_d;
    logic        we_q, we_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  vid_rdata_q, vid_rdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        pick_cpu;
    logic [7:0]  rd_byte;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_cpu_q   <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_cpu_q   <= gnt_cpu_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_cpu_d    = gnt_cpu_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        vid_rdata_d  = vid_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        pick_cpu     = 1'b0;
        rd_byte      = addr_q[19] ? sram_d_i[15:8] : sram_d_i[7:0];
        sram_a       = '0;
        sram_d_o     = '0;
        sram_d_oe_hi = 1'b0;
        sram_d_oe_lo = 1'b0;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_ce_n    = 4'hF;
        vid_ack      = 1'b0;
        cpu_ack      = 1'b0;

        // Address, chip select and lane drive stay stable from SETUP through HOLD.
        if (state_q != IDLE) begin
            sram_a    = addr_q[18:0];
            sram_ce_n = ~(4'b0001 << addr_q[20:19]);
            if (we_q) begin
                sram_d_o     = {wdata_q, wdata_q};
                sram_d_oe_hi = addr_q[19];
                sram_d_oe_lo = ~addr_q[19];
            end
        end

        case (state_q)
            IDLE: begin
                if (vid_req || cpu_req) begin
                    pick_cpu  = cpu_req && (!vid_req || !gnt_cpu_q);
                    gnt_cpu_d = pick_cpu;
                    addr_d    = pick_cpu ? cpu_addr : vid_addr;
                    we_d      = pick_cpu && cpu_we;
                    wdata_d   = cpu_wdata;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    sram_we_n = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                    if (!we_q) begin
                        if (gnt_cpu_q) begin
                            cpu_rdata_d = rd_byte;
                        end else begin
                            vid_rdata_d = rd_byte;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                cpu_ack = gnt_cpu_q;
                vid_ack = ~gnt_cpu_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign vid_rdata = vid_rdata_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// Self-checking bench for sram_arbiter: table of single accesses plus tie, reset and back-to-back sequences.
module tb_sram_arbiter;

    localparam int AC = 2;

    logic        clk_100 = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [20:0] vid_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [20:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [15:0] sram_d_i = '0;
    logic        vid_ack, cpu_ack, sram_d_oe_hi, sram_d_oe_lo, sram_we_n, sram_oe_n;
    logic [7:0]  vid_rdata, cpu_rdata;
    logic [18:0] sram_a;
    logic [15:0] sram_d_o;
    logic [3:0]  sram_ce_n;

    // Second instance with single-cycle strobes
    logic        cpu_req1 = 1'b0;
    logic [20:0] cpu_addr1 = '0;
    logic [15:0] sram_d_i1 = '0;
    logic        vid_ack1, cpu_ack1, oe_hi1, oe_lo1, we_n1, oe_n1;
    logic [7:0]  vid_rdata1, cpu_rdata1;
    logic [18:0] sram_a1;
    logic [15:0] sram_d_o1;
    logic [3:0]  ce_n1;

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_vid_rd = 8'h00;

    always #5 clk_100 = ~clk_100;

    sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk_100(clk_100), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_oe_hi(sram_d_oe_hi),
        .sram_d_oe_lo(sram_d_oe_lo), .sram_d_i(sram_d_i), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n)
    );

    sram_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk_100(clk_100), .reset_n(reset_n),
        .vid_req(1'b0), .vid_addr(21'h0), .vid_ack(vid_ack1), .vid_rdata(vid_rdata1),
        .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_wdata(8'h00),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .sram_a(sram_a1), .sram_d_o(sram_d_o1), .sram_d_oe_hi(oe_hi1),
        .sram_d_oe_lo(oe_lo1), .sram_d_i(sram_d_i1), .sram_we_n(we_n1),
        .sram_oe_n(oe_n1), .sram_ce_n(ce_n1)
    );

    typedef struct {
        bit          cpu;
        bit          we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [15:0] din;
        logic [3:0]  ce;
        logic [18:0] a;
        bit          hi;
        bit          lo;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  we_low;
        int  oe_low;
        bit  done;
        we_low = 0;
        oe_low = 0;
        done   = 0;
        @(negedge clk_100);
        if (v.cpu) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            vid_req = 1'b1; vid_addr = v.addr;
        end
        sram_d_i = v.din;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk_100);
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n && !sram_oe_n) chk($sformatf("v%0d we_oe_overlap", idx), 1, 0);
            if (k == 1) begin
                chk($sformatf("v%0d setup_ce_n", idx), sram_ce_n, v.ce);
                chk($sformatf("v%0d setup_a", idx), sram_a, v.a);
                chk($sformatf("v%0d setup_oe_hi", idx), sram_d_oe_hi, v.hi);
                chk($sformatf("v%0d setup_oe_lo", idx), sram_d_oe_lo, v.lo);
                chk($sformatf("v%0d setup_we_n", idx), sram_we_n, 1);
                if (v.we) chk($sformatf("v%0d d_o", idx), sram_d_o, {v.wdata, v.wdata});
            end
            if (vid_ack || cpu_ack) begin
                done = 1;
                chk($sformatf("v%0d latency", idx), k, AC + 2);
                chk($sformatf("v%0d ack_port_cpu", idx), {cpu_ack, vid_ack}, v.cpu ? 2'b10 : 2'b01);
                chk($sformatf("v%0d hold_we_n", idx), sram_we_n, 1);
                chk($sformatf("v%0d hold_ce_n", idx), sram_ce_n, v.ce);
                chk($sformatf("v%0d hold_a", idx), sram_a, v.a);
                chk($sformatf("v%0d hold_lanes", idx), {sram_d_oe_hi, sram_d_oe_lo}, {v.hi, v.lo});
                chk($sformatf("v%0d we_low_cycles", idx), we_low, v.we ? AC : 0);
                chk($sformatf("v%0d oe_low_cycles", idx), oe_low, v.we ? 0 : AC);
                if (!v.we) begin
                    if (v.cpu) exp_cpu_rd = v.rd;
                    else       exp_vid_rd = v.rd;
                end
                chk($sformatf("v%0d cpu_rdata", idx), cpu_rdata, exp_cpu_rd);
                chk($sformatf("v%0d vid_rdata", idx), vid_rdata, exp_vid_rd);
                cpu_req = 1'b0;
                vid_req = 1'b0;
            end
        end
        if (!done) begin
            chk($sformatf("v%0d ack_timeout", idx), 0, 1);
            cpu_req = 1'b0;
            vid_req = 1'b0;
        end
        @(negedge clk_100);
        chk($sformatf("v%0d idle_ce_n", idx), sram_ce_n, 4'hF);
        chk($sformatf("v%0d idle_rdata_held", idx), {cpu_rdata, vid_rdata}, {exp_cpu_rd, exp_vid_rd});
    endtask

    initial begin
        int ack_seq[$];
        int ack_time[$];
        int we1_low;

        vecs[0] = '{1'b1, 1'b1, 21'h0A1234, 8'h5A, 16'h0000, 4'b1101, 19'h21234, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 21'h100000, 8'h00, 16'hBEEF, 4'b1011, 19'h00000, 1'b0, 1'b0, 8'hEF};
        vecs[2] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 16'h1234, 4'b0111, 19'h7FFFF, 1'b0, 1'b0, 8'h12};
        vecs[3] = '{1'b1, 1'b1, 21'h000010, 8'hA5, 16'hFFFF, 4'b1110, 19'h00010, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 21'h080001, 8'h00, 16'hCAFE, 4'b1101, 19'h00001, 1'b0, 1'b0, 8'hCA};
        vecs[5] = '{1'b1, 1'b0, 21'h130003, 8'h00, 16'h55AA, 4'b1011, 19'h30003, 1'b0, 1'b0, 8'hAA};

        // Reset state
        #2;
        chk("rst_ce_n", sram_ce_n, 4'hF);
        chk("rst_strobes", {sram_we_n, sram_oe_n}, 2'b11);
        chk("rst_lanes_acks", {sram_d_oe_hi, sram_d_oe_lo, vid_ack, cpu_ack}, 4'b0000);
        chk("rst_a_d", {sram_a, sram_d_o}, 35'h0);
        chk("rst_rdata", {cpu_rdata, vid_rdata}, 16'h0);
        @(negedge clk_100);
        @(negedge clk_100);
        reset_n = 1'b1;

        // Both requests held continuously out of reset: video wins the first tie, then alternation
        vid_addr = 21'h000100; cpu_addr = 21'h000200; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        for (int k = 1; k <= 40 && ack_seq.size() < 4; k++) begin
            @(negedge clk_100);
            if (vid_ack && cpu_ack) chk("tie_ack_overlap", 1, 0);
            if (vid_ack || cpu_ack) begin
                ack_seq.push_back(cpu_ack ? 1 : 0);
                ack_time.push_back(k);
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("tie_ack_count", ack_seq.size(), 4);
        if (ack_seq.size() == 4) begin
            chk("tie_order", {ack_seq[0][0], ack_seq[1][0], ack_seq[2][0], ack_seq[3][0]}, 4'b0101);
            chk("tie_first_latency", ack_time[0], AC + 2);
            for (int i = 1; i < 4; i++)
                chk($sformatf("tie_spacing%0d", i), ack_time[i] - ack_time[i-1], AC + 3);
        end
        @(negedge clk_100);
        exp_cpu_rd = cpu_rdata;
        exp_vid_rd = vid_rdata;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset during the second ACCESS cycle of a write
        @(negedge clk_100);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h0A1234; cpu_wdata = 8'h5A;
        @(negedge clk_100);
        @(negedge clk_100);
        @(negedge clk_100);
        chk("mid_we_n_before_reset", sram_we_n, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we_n", sram_we_n, 1);
        chk("mid_rst_ce_n", sram_ce_n, 4'hF);
        chk("mid_rst_acks", {cpu_ack, vid_ack}, 2'b00);
        chk("mid_rst_a_d_lanes", {sram_a, sram_d_o, sram_d_oe_hi, sram_d_oe_lo}, 37'h0);
        chk("mid_rst_rdata", {cpu_rdata, vid_rdata}, 16'h0);
        cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_100);
            if (cpu_ack) chk("mid_rst_spurious_ack", 1, 0);
        end
        reset_n = 1'b1;
        exp_cpu_rd = 8'h00;
        exp_vid_rd = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_100);
            if (cpu_ack || vid_ack) chk("post_rst_spurious_ack", 1, 0);
        end
        run_vec(vecs[0], 10);
        run_vec(vecs[1], 11);

        // Single-cycle strobes, back-to-back CPU reads
        ack_time.delete();
        we1_low = 0;
        @(negedge clk_100);
        cpu_addr1 = 21'h180005; sram_d_i1 = 16'h9C3E; cpu_req1 = 1'b1;
        for (int k = 1; k <= 30 && ack_time.size() < 3; k++) begin
            @(negedge clk_100);
            if (!we_n1) we1_low++;
            if (k == 1) chk("ac1_setup_ce_n", ce_n1, 4'b0111);
            if (cpu_ack1) begin
                ack_time.push_back(k);
                chk($sformatf("ac1_rdata%0d", ack_time.size()), cpu_rdata1, 8'h9C);
            end
        end
        cpu_req1 = 1'b0;
        chk("ac1_ack_count", ack_time.size(), 3);
        if (ack_time.size() == 3) begin
            chk("ac1_latency", ack_time[0], 3);
            chk("ac1_spacing1", ack_time[1] - ack_time[0], 4);
            chk("ac1_spacing2", ack_time[2] - ack_time[1], 4);
        end
        chk("ac1_we_n_never_low", we1_low, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ACCESS_CYCLES, default 2, number of strobe cycles per SRAM access; legal range 1..15.
REQ-002 clk_100  input  1  system clock; all state on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 vid_req  input  1  video read request; held high until vid_ack.
REQ-005 vid_addr  input  21  video byte address; [20:19] chip, [18:0] word.
REQ-006 vid_ack  output  1  one-cycle pulse; vid_rdata valid in the same cycle.
REQ-007 vid_rdata  output  8  video read byte.
REQ-008 cpu_req  input  1  CPU request; held high until cpu_ack.
REQ-009 cpu_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-010 cpu_addr  input  21  CPU byte address; same split as vid_addr.
REQ-011 cpu_wdata  input  8  CPU write byte.
REQ-012 cpu_ack  output  1  one-cycle pulse; cpu_rdata valid in the same cycle on reads.
REQ-013 cpu_rdata  output  8  CPU read byte.
REQ-014 sram_a  output  19  SRAM word address.
REQ-015 sram_d_o  output  16  write data; the byte is replicated on both lanes.
REQ-016 sram_d_oe_hi / sram_d_oe_lo  output  1 each  drive enables for SRAM_D[15:8] / [7:0].
REQ-017 sram_d_i  input  16  SRAM read data.
REQ-018 sram_we_n  output  1  write strobe, active-low.
REQ-019 sram_oe_n  output  1  output enable, active-low.
REQ-020 sram_ce_n  output  4  chip enables, active-low, one per addr[20:19] value.

Function
REQ-021 States SHALL be IDLE, SETUP, ACCESS and HOLD; only IDLE arbitrates.
REQ-022 In IDLE with exactly one request high, that port SHALL be granted.
REQ-023 If both requests are high, the port not granted last SHALL win; last_grant SHALL reset to CPU, so video wins the first tie.
REQ-024 At grant, address, we and wdata SHALL be latched, and the state SHALL go to SETUP; requester inputs are ignored until ack.
REQ-025 SETUP (1 cycle) SHALL drive:
- sram_a = addr[18:0];
- sram_ce_n[addr[20:19]] = 0, all other ce_n bits 1;
- on writes, the lane enable: hi if addr[19]=1, else lo.
REQ-026 ACCESS SHALL last exactly ACCESS_CYCLES cycles:
- writes: sram_we_n = 0, sram_oe_n = 1;
- reads: sram_oe_n = 0, sram_we_n = 1.
REQ-027 On reads, sram_d_i SHALL be registered on the last ACCESS cycle, selecting [15:8] if addr[19]=1, else [7:0].
REQ-028 HOLD (1 cycle) SHALL behave as follows:
- sram_we_n = 1;
- address, ce_n and lane enable held, so write data outlives the WE rising edge;
- the granted port's ack pulses high;
- next state is IDLE.
REQ-029 Latency from grant cycle to ack SHALL be ACCESS_CYCLES+2 cycles; minimum request-to-request spacing SHALL be ACCESS_CYCLES+3 cycles.
REQ-030 In IDLE, ce_n SHALL be 4'hF, we_n and oe_n 1, and both lane enables 0.
REQ-031 At most one ce_n bit SHALL be low, and at most one lane enable high, in any cycle.
REQ-032 sram_we_n low SHALL never coincide with sram_oe_n low, and never occur in SETUP or HOLD.
REQ-033 Video requests SHALL never assert we_n.
REQ-034 vid_ack and cpu_ack SHALL never be high in the same cycle.
REQ-035 rdata outputs SHALL hold their value until that port's next read ack.
REQ-036 A request deasserted before its ack SHALL still complete the access; the ack is still issued.

Reset
REQ-037 reset_n low SHALL immediately force the following, including mid-access, with no ack issued:
- state IDLE;
- sram_we_n = 1, sram_oe_n = 1, sram_ce_n = 4'hF;
- both lane enables 0;
- sram_a = 0, sram_d_o = 0;
- both acks 0, both rdata = 0;
- last_grant = CPU.
REQ-038 After reset_n rises, the first arbitration SHALL occur on the first clock edge that sees a request in IDLE.

Verification
REQ-039 CPU write, addr 0x0A_1234 (chip 01), wdata 0x5A, ACCESS_CYCLES=2:
- ce_n = 4'b1101, sram_a = 0x21234, oe_hi = 1;
- we_n low exactly 2 cycles;
- cpu_ack 4 cycles after grant.
REQ-040 CPU read, addr 0x10_0000 (chip 10), sram_d_i = 0xBEEF -> cpu_rdata = 0xEF, ce_n = 4'b1011, oe_n low 2 cycles, no lane enable.
REQ-041 vid_req and cpu_req both held high continuously out of reset -> grants alternate video, CPU, video, CPU; acks never overlap.
REQ-042 reset_n pulled low during the second ACCESS cycle of a write -> we_n = 1 and ce_n = 4'hF immediately, no cpu_ack; a fresh request after release completes normally.
REQ-043 ACCESS_CYCLES=1, CPU reads back-to-back -> 3-cycle ack latency and 4-cycle spacing; we_n stays 1 throughout.
